stage_demux: RTL and testbench



---
 rtl/stage_pkg.sv | 7 +
 rtl/stage_demux_if.sv | 23 ++
 rtl/stage_demux_slot.sv | 43 ++++
 rtl/stage_demux.sv | 33 +++
 tb/tb_stage_demux.sv | 298 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/stage_pkg.sv
// stage_pkg: shared constants and slot state type for the stage demultiplexer
package stage_pkg;
   localparam int DATA_W = 8;
   localparam logic SEL_A = 1'b1;
   localparam logic SEL_B = 1'b0;
   typedef enum logic {SLOT_EMPTY, SLOT_FULL} slot_state_t;
endpackage

// File: rtl/stage_demux_if.sv
// stage_demux_if: input stream (valid/ready/data/sel) plus output ports A and B
//   slave  : demux view (consumes in_*, produces a_*/b_*)
//   master : environment view (produces in_*, consumes a_*/b_*)
interface stage_demux_if import stage_pkg::*; #(parameter int W = DATA_W) ();
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] in_data;
   logic         in_sel;
   logic         a_valid;
   logic         a_ready;
   logic [W-1:0] a_data;
   logic         b_valid;
   logic         b_ready;
   logic [W-1:0] b_data;
   modport slave (
      input  in_valid, in_data, in_sel, a_ready, b_ready,
      output in_ready, a_valid, a_data, b_valid, b_data
   );
   modport master (
      output in_valid, in_data, in_sel, a_ready, b_ready,
      input  in_ready, a_valid, a_data, b_valid, b_data
   );
endinterface

// File: rtl/stage_demux_slot.sv
// demux_slot: one-entry output register with load/valid/ready handshake
//   clk, rst : clock, synchronous active-high reset
//   load, din: write a beat (caller only loads when avail=1)
//   ready    : consumer accepts; valid, data: held beat
//   avail    : slot can take a beat this cycle (empty, or draining now)
//   count    : drain counter, only with STAGE_DEMUX_STATS_EN
module demux_slot import stage_pkg::*; #(parameter int W = DATA_W) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic [W-1:0] din,
   input  logic         ready,
   output logic         valid,
   output logic [W-1:0] data,
   output logic         avail
`ifdef STAGE_DEMUX_STATS_EN
   ,
   output logic [15:0]  count
`endif
);
   slot_state_t state_q, state_d;
   assign valid = state_q == SLOT_FULL;
   assign avail = !valid || ready;
   // a load wins over a drain so a simultaneous drain+load stays FULL
   always_comb begin
      state_d = load ? SLOT_FULL : (valid && ready) ? SLOT_EMPTY : state_q;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= SLOT_EMPTY;
         data    <= '0;
      end else begin
         state_q <= state_d;
         if (load) data <= din;
      end
   end
`ifdef STAGE_DEMUX_STATS_EN
   always_ff @(posedge clk) begin
      if (rst) count <= '0;
      else if (valid && ready) count <= count + 16'd1;
   end
`endif
endmodule

// File: rtl/stage_demux.sv
// stage_demux: steers a valid/ready stream to port A (sel=1) or port B (sel=0)
//   clk, rst : clock, synchronous active-high reset
//   bus      : stage_demux_if slave (in_*, a_*, b_*)
//   a_count, b_count : per-port drain counters, only with STAGE_DEMUX_STATS_EN
module stage_demux import stage_pkg::*; #(parameter int W = DATA_W) (
   input logic clk,
   input logic rst,
   stage_demux_if.slave bus
`ifdef STAGE_DEMUX_STATS_EN
   ,
   output logic [15:0] a_count,
   output logic [15:0] b_count
`endif
);
   logic avail_a, avail_b, xfer;
   // only the selected port's readiness matters; independent of in_valid
   assign bus.in_ready = bus.in_sel == SEL_A ? avail_a : avail_b;
   assign xfer = bus.in_valid && bus.in_ready;
   demux_slot #(.W(W)) u_a (
      .clk(clk), .rst(rst), .load(xfer && bus.in_sel == SEL_A), .din(bus.in_data),
      .ready(bus.a_ready), .valid(bus.a_valid), .data(bus.a_data), .avail(avail_a)
`ifdef STAGE_DEMUX_STATS_EN
      , .count(a_count)
`endif
   );
   demux_slot #(.W(W)) u_b (
      .clk(clk), .rst(rst), .load(xfer && bus.in_sel == SEL_B), .din(bus.in_data),
      .ready(bus.b_ready), .valid(bus.b_valid), .data(bus.b_data), .avail(avail_b)
`ifdef STAGE_DEMUX_STATS_EN
      , .count(b_count)
`endif
   );
endmodule

// File: tb/tb_stage_demux.sv
// tb_stage_demux: scenario tasks plus a per-port scoreboard of accepted beats
module tb_stage_demux;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int errors = 0;
   int checks = 0;
   logic [7:0] qa[$];
   logic [7:0] qb[$];
   logic [7:0] exp_v;
`ifdef STAGE_DEMUX_STATS_EN
   logic [15:0] a_count, b_count;
`endif
   stage_demux_if #(.W(8)) bus();
   stage_demux #(.W(8)) dut (
      .clk(clk), .rst(rst), .bus(bus.slave)
`ifdef STAGE_DEMUX_STATS_EN
      , .a_count(a_count), .b_count(b_count)
`endif
   );
   always #5 clk = ~clk;

   // at negedge: drains this cycle pop and compare, accepted beats push
   always @(negedge clk) begin
      if (rst) begin
         qa.delete();
         qb.delete();
      end else begin
         if (bus.a_valid && bus.a_ready) begin
            checks++;
            if (qa.size() == 0) begin
               errors++;
               $display("FAIL sb_a: unexpected drain data=%h, required none", bus.a_data);
            end else begin
               exp_v = qa.pop_front();
               if (bus.a_data !== exp_v) begin
                  errors++;
                  $display("FAIL sb_a: a_data=%h required=%h", bus.a_data, exp_v);
               end
            end
         end
         if (bus.b_valid && bus.b_ready) begin
            checks++;
            if (qb.size() == 0) begin
               errors++;
               $display("FAIL sb_b: unexpected drain data=%h, required none", bus.b_data);
            end else begin
               exp_v = qb.pop_front();
               if (bus.b_data !== exp_v) begin
                  errors++;
                  $display("FAIL sb_b: b_data=%h required=%h", bus.b_data, exp_v);
               end
            end
         end
         if (bus.in_valid && bus.in_ready) begin
            if (bus.in_sel) qa.push_back(bus.in_data);
            else qb.push_back(bus.in_data);
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic s, input logic [7:0] d);
      bus.in_valid = v;
      bus.in_sel = s;
      bus.in_data = d;
      #1;
   endtask

   task automatic test_reset();
      drive(1'b1, 1'b1, 8'h5A);
      bus.a_ready = 1'b0;
      bus.b_ready = 1'b0;
      step();
      drive(1'b1, 1'b0, 8'h6B);
      step();
      drive(1'b0, 1'b0, 8'h00);
      rst = 1'b1;
      step();
      step();
      rst = 1'b0;
      step();
      checks++;
      if (bus.a_valid !== 1'b0 || bus.b_valid !== 1'b0) begin
         errors++;
         $display("FAIL reset_valid: a_valid=%b b_valid=%b required 0 0", bus.a_valid, bus.b_valid);
      end
      checks++;
      if (bus.a_data !== 8'h00 || bus.b_data !== 8'h00) begin
         errors++;
         $display("FAIL reset_data: a_data=%h b_data=%h required 00 00", bus.a_data, bus.b_data);
      end
   endtask

   task automatic test_single_route();
      bus.a_ready = 1'b0;
      drive(1'b1, 1'b1, 8'hA5);
      checks++;
      if (bus.in_ready !== 1'b1) begin
         errors++;
         $display("FAIL single_ready: in_ready=%b required 1", bus.in_ready);
      end
      step();
      drive(1'b0, 1'b0, 8'hFF);
      checks++;
      if (bus.a_valid !== 1'b1 || bus.a_data !== 8'hA5 || bus.b_valid !== 1'b0) begin
         errors++;
         $display("FAIL single_out: a_valid=%b a_data=%h b_valid=%b required 1 a5 0",
                  bus.a_valid, bus.a_data, bus.b_valid);
      end
      bus.a_ready = 1'b1;
      step();
      bus.a_ready = 1'b0;
      checks++;
      if (bus.a_valid !== 1'b0) begin
         errors++;
         $display("FAIL single_drain: a_valid=%b required 0", bus.a_valid);
      end
   endtask

   task automatic test_backpressure();
      bus.a_ready = 1'b0;
      drive(1'b1, 1'b1, 8'h11);
      step();
      drive(1'b1, 1'b1, 8'h22);
      for (int i = 0; i < 3; i++) begin
         checks++;
         if (bus.in_ready !== 1'b0 || bus.a_valid !== 1'b1 || bus.a_data !== 8'h11) begin
            errors++;
            $display("FAIL bp_stall%0d: in_ready=%b a_valid=%b a_data=%h required 0 1 11",
                     i, bus.in_ready, bus.a_valid, bus.a_data);
         end
         step();
      end
      bus.a_ready = 1'b1;
      #1;
      checks++;
      if (bus.in_ready !== 1'b1) begin
         errors++;
         $display("FAIL bp_release: in_ready=%b required 1", bus.in_ready);
      end
      step();
      drive(1'b0, 1'b0, 8'h00);
      checks++;
      if (bus.a_valid !== 1'b1 || bus.a_data !== 8'h22) begin
         errors++;
         $display("FAIL bp_next: a_valid=%b a_data=%h required 1 22", bus.a_valid, bus.a_data);
      end
      step();
      bus.a_ready = 1'b0;
      checks++;
      if (bus.a_valid !== 1'b0 || bus.a_data !== 8'h22) begin
         errors++;
         $display("FAIL bp_hold: a_valid=%b a_data=%h required 0 22", bus.a_valid, bus.a_data);
      end
   endtask

   task automatic test_streaming();
      bus.b_ready = 1'b1;
      for (int i = 1; i <= 4; i++) begin
         drive(1'b1, 1'b0, 8'(i));
         checks++;
         if (bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL stream_ready%0d: in_ready=%b required 1", i, bus.in_ready);
         end
         step();
         checks++;
         if (bus.b_valid !== 1'b1 || bus.b_data !== 8'(i)) begin
            errors++;
            $display("FAIL stream_out%0d: b_valid=%b b_data=%h required 1 %h",
                     i, bus.b_valid, bus.b_data, 8'(i));
         end
      end
      drive(1'b0, 1'b0, 8'h00);
      step();
      bus.b_ready = 1'b0;
      checks++;
      if (bus.b_valid !== 1'b0) begin
         errors++;
         $display("FAIL stream_end: b_valid=%b required 0", bus.b_valid);
      end
   endtask

   task automatic test_independence();
      bus.a_ready = 1'b0;
      bus.b_ready = 1'b0;
      drive(1'b1, 1'b1, 8'h33);
      step();
      drive(1'b1, 1'b0, 8'h44);
      checks++;
      if (bus.in_ready !== 1'b1) begin
         errors++;
         $display("FAIL indep_ready: in_ready=%b required 1", bus.in_ready);
      end
      step();
      checks++;
      if (bus.b_valid !== 1'b1 || bus.b_data !== 8'h44 || bus.a_valid !== 1'b1 || bus.a_data !== 8'h33) begin
         errors++;
         $display("FAIL indep_out: b_valid=%b b_data=%h a_valid=%b a_data=%h required 1 44 1 33",
                  bus.b_valid, bus.b_data, bus.a_valid, bus.a_data);
      end
      bus.a_ready = 1'b1;
      bus.b_ready = 1'b1;
      drive(1'b1, 1'b1, 8'h55);
      checks++;
      if (bus.in_ready !== 1'b1) begin
         errors++;
         $display("FAIL indep_dual_ready: in_ready=%b required 1", bus.in_ready);
      end
      step();
      drive(1'b0, 1'b0, 8'h00);
      checks++;
      if (bus.a_valid !== 1'b1 || bus.a_data !== 8'h55 || bus.b_valid !== 1'b0) begin
         errors++;
         $display("FAIL indep_dual: a_valid=%b a_data=%h b_valid=%b required 1 55 0",
                  bus.a_valid, bus.a_data, bus.b_valid);
      end
      step();
      bus.a_ready = 1'b0;
      bus.b_ready = 1'b0;
      checks++;
      if (bus.a_valid !== 1'b0) begin
         errors++;
         $display("FAIL indep_end: a_valid=%b required 0", bus.a_valid);
      end
   endtask

`ifdef STAGE_DEMUX_STATS_EN
   task automatic test_stats();
      rst = 1'b1;
      step();
      rst = 1'b0;
      bus.a_ready = 1'b1;
      bus.b_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         drive(1'b1, i < 3, 8'(8'h80 + i));
         step();
      end
      drive(1'b0, 1'b0, 8'h00);
      step();
      step();
      checks++;
      if (a_count !== 16'd3 || b_count !== 16'd5) begin
         errors++;
         $display("FAIL stats_count: a_count=%0d b_count=%0d required 3 5", a_count, b_count);
      end
      force dut.u_a.count = 16'hFFFF;
      #1;
      release dut.u_a.count;
      drive(1'b1, 1'b1, 8'h77);
      step();
      drive(1'b0, 1'b0, 8'h00);
      step();
      checks++;
      if (a_count !== 16'h0000) begin
         errors++;
         $display("FAIL stats_wrap: a_count=%h required 0000", a_count);
      end
      bus.a_ready = 1'b0;
      bus.b_ready = 1'b0;
   endtask
`endif

   task automatic test_drained();
      step();
      checks++;
      if (qa.size() != 0 || qb.size() != 0) begin
         errors++;
         $display("FAIL sb_leftover: qa=%0d qb=%0d required 0 0", qa.size(), qb.size());
      end
   endtask

   initial begin
      bus.in_valid = 1'b0;
      bus.in_sel = 1'b0;
      bus.in_data = 8'h00;
      bus.a_ready = 1'b0;
      bus.b_ready = 1'b0;
      step();
      step();
      rst = 1'b0;
      test_reset();
      test_single_route();
      test_backpressure();
      test_streaming();
      test_independence();
`ifdef STAGE_DEMUX_STATS_EN
      test_stats();
`endif
      test_drained();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
